ethpipe: RTL and testbench

ETHPIPE -- requirements
Module: ethpipe

---
 rtl/ethpipe_pkg.sv | 32 +++
 rtl/ethpipe_if.sv | 11 +
 rtl/ethpipe_rx.sv | 143 ++++++++++++++
 rtl/ethpipe.sv | 42 ++++
 tb/tb_ethpipe.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ethpipe_pkg.sv
// Shared constants, receive-state enumeration and slot address helper for the
// ethpipe GMII receive path.
package ethpipe_pkg;

    localparam logic [7:0]  PREAMBLE       = 8'h55;
    localparam logic [7:0]  SFD            = 8'hD5;
    localparam int          HDR_WORDS      = 4;
    localparam logic [10:0] SLOT_LAST_ADDR = 11'd2047;

    // Data words run from HDR_WORDS up to SLOT_LAST_ADDR, four bytes each.
    localparam int MAX_DATA_BYTES = (int'(SLOT_LAST_ADDR) - HDR_WORDS + 1) * 4;

    localparam logic [10:0] ADDR_LEN = 11'd0;
    localparam logic [10:0] ADDR_TSL = 11'd1;
    localparam logic [10:0] ADDR_TSH = 11'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP,
        ST_HDR_LEN,
        ST_HDR_TSL,
        ST_HDR_TSH,
        ST_DONE
    } rx_state_t;

    function automatic logic [10:0] data_word_addr(input logic [10:0] word_idx);
        return 11'(HDR_WORDS) + word_idx;
    endfunction

endpackage

// File: rtl/ethpipe_if.sv
// Receive slot RAM write port: the receiver is master, the RAM side is slave.
interface ethpipe_if;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic [10:0] address;
    logic        wr_en;
    logic [31:0] q;

    modport master (output data, byte_en, address, wr_en, input q);
    modport slave  (input data, byte_en, address, wr_en, output q);
endinterface

// File: rtl/ethpipe_rx.sv
// GMII receive engine: registers the GMII inputs, stores frame data into the
// slot RAM from word HDR_WORDS upward, then writes the length/timestamp header.
//
// state       | meaning
// ST_IDLE     | waiting for the first preamble byte
// ST_PREAMBLE | inside preamble, waiting for SFD
// ST_DATA     | storing data bytes one lane per write
// ST_DROP     | discarding an error/unwanted frame until dv falls
// ST_HDR_LEN  | writing word 0 = byte count
// ST_HDR_TSL  | writing word 1 = timestamp low
// ST_HDR_TSH  | writing word 2 = timestamp high
// ST_DONE     | raising rx_complete
module ethpipe_rx
    import ethpipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_empty,
    input  logic [63:0] global_counter,
    ethpipe_if.master   slot,
    output logic        rx_complete
);

    rx_state_t   state, state_nx;
    logic [7:0]  rxd_r;
    logic        dv_r;
    logic [15:0] byte_cnt, cnt_nx;
    logic [63:0] timestamp, ts_nx;
    logic        wr_en_r, wr_nx;
    logic [10:0] addr_r, addr_nx;
    logic [31:0] data_r, data_nx;
    logic [3:0]  be_r, be_nx;
    logic        complete_r, cmp_nx;
    logic        unused_q;

    assign unused_q = ^slot.q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_r      <= '0;
            dv_r       <= 1'b0;
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            timestamp  <= '0;
            wr_en_r    <= 1'b0;
            addr_r     <= '0;
            data_r     <= '0;
            be_r       <= '0;
            complete_r <= 1'b0;
        end else begin
            rxd_r      <= rxd;
            dv_r       <= rx_dv;
            state      <= state_nx;
            byte_cnt   <= cnt_nx;
            timestamp  <= ts_nx;
            wr_en_r    <= wr_nx;
            addr_r     <= addr_nx;
            data_r     <= data_nx;
            be_r       <= be_nx;
            complete_r <= cmp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = byte_cnt;
        ts_nx    = timestamp;
        wr_nx    = 1'b0;
        addr_nx  = addr_r;
        data_nx  = data_r;
        be_nx    = be_r;
        cmp_nx   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dv_r) state_nx = (rxd_r == PREAMBLE) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!dv_r) begin
                    state_nx = ST_IDLE;
                end else if (rxd_r == SFD) begin
                    ts_nx    = global_counter;
                    cnt_nx   = '0;
                    state_nx = rx_empty ? ST_DATA : ST_DROP;
                end else if (rxd_r != PREAMBLE) begin
                    state_nx = ST_DROP;
                end
            end
            ST_DATA: begin
                if (dv_r) begin
                    // Bytes past the last slot word are silently discarded.
                    if (byte_cnt < 16'(MAX_DATA_BYTES)) begin
                        wr_nx   = 1'b1;
                        addr_nx = data_word_addr(byte_cnt[12:2]);
                        be_nx   = 4'b0001 << byte_cnt[1:0];
                        data_nx = {4{rxd_r}};
                        cnt_nx  = byte_cnt + 16'd1;
                    end
                end else begin
                    state_nx = (byte_cnt != '0) ? ST_HDR_LEN : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!dv_r) state_nx = ST_IDLE;
            end
            ST_HDR_LEN: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_LEN;
                be_nx    = 4'hF;
                data_nx  = {16'h0, byte_cnt};
                state_nx = ST_HDR_TSL;
            end
            ST_HDR_TSL: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_TSL;
                be_nx    = 4'hF;
                data_nx  = timestamp[31:0];
                state_nx = ST_HDR_TSH;
            end
            ST_HDR_TSH: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_TSH;
                be_nx    = 4'hF;
                data_nx  = timestamp[63:32];
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                cmp_nx   = 1'b1;
                // A frame that began while the header was going out is an error frame.
                state_nx = dv_r ? ST_DROP : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign slot.wr_en   = wr_en_r;
    assign slot.address = addr_r;
    assign slot.data    = data_r;
    assign slot.byte_en = be_r;
    assign rx_complete  = complete_r;

endmodule

// File: rtl/ethpipe.sv
// ethpipe top: 64-bit timestamp counter, constant idle GMII transmit side and
// the receive engine writing frames into the RX slot RAM.
module ethpipe (
    input  logic        pci_clk,
    input  logic        sys_rst,
    input  logic        gmii_rx_clk,
    input  logic        gmii_tx_clk,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    input  logic        global_counter_rst,
    output logic [63:0] global_counter,
    ethpipe_if.master   slot,
    input  logic        rx_empty,
    output logic        rx_complete
);

    // GMII clocks are identical to pci_clk and kept only for pin compatibility.
    logic unused_clks;
    assign unused_clks = gmii_rx_clk ^ gmii_tx_clk;

    assign gmii_txd   = 8'h00;
    assign gmii_tx_en = 1'b0;

    always_ff @(posedge pci_clk) begin
        if (sys_rst || global_counter_rst) global_counter <= '0;
        else                               global_counter <= global_counter + 64'd1;
    end

    ethpipe_rx u_rx (
        .clk            (pci_clk),
        .rst            (sys_rst),
        .rxd            (gmii_rxd),
        .rx_dv          (gmii_rx_dv),
        .rx_empty       (rx_empty),
        .global_counter (global_counter),
        .slot           (slot),
        .rx_complete    (rx_complete)
    );

endmodule

// File: tb/tb_ethpipe.sv
// Self-checking bench for ethpipe: directed and randomized frames against a
// frame-level scoreboard of expected slot writes and rx_complete pulses.
module tb_ethpipe;
    import ethpipe_pkg::*;

    logic        pci_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        gmii_rx_clk, gmii_tx_clk;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        global_counter_rst = 1'b0;
    logic [63:0] global_counter;
    logic        rx_empty = 1'b0;
    logic        rx_complete;

    ethpipe_if slot_if ();

    ethpipe dut (
        .pci_clk            (pci_clk),
        .sys_rst            (sys_rst),
        .gmii_rx_clk        (gmii_rx_clk),
        .gmii_tx_clk        (gmii_tx_clk),
        .gmii_rxd           (gmii_rxd),
        .gmii_rx_dv         (gmii_rx_dv),
        .gmii_txd           (gmii_txd),
        .gmii_tx_en         (gmii_tx_en),
        .global_counter_rst (global_counter_rst),
        .global_counter     (global_counter),
        .slot               (slot_if),
        .rx_empty           (rx_empty),
        .rx_complete        (rx_complete)
    );

    always #5 pci_clk = ~pci_clk;
    assign gmii_rx_clk = pci_clk;
    assign gmii_tx_clk = pci_clk;
    assign slot_if.q   = 32'h0;

    typedef struct {
        int          cyc;
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    int          cq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] exp_cnt = 64'd0;
    logic        rst_q = 1'b1;
    int          n_wr = 0;
    int          n_cmp = 0;
    logic [31:0] hdr_len_seen = 32'h0;
    int          rx_free = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timestamp counter and cycle index, advanced at every active edge.
    always @(posedge pci_clk) begin
        cyc     = cyc + 1;
        rst_q   = sys_rst;
        exp_cnt = (sys_rst || global_counter_rst) ? 64'd0 : exp_cnt + 64'd1;
    end

    always @(negedge pci_clk) begin
        chk("global_counter", global_counter, exp_cnt);
        chk("gmii_tx", {55'h0, gmii_tx_en, gmii_txd}, 64'h0);
        if (rst_q) begin
            chk("rst_wr_en", {63'h0, slot_if.wr_en}, 64'h0);
            chk("rst_rx_complete", {63'h0, rx_complete}, 64'h0);
            chk("rst_address", {53'h0, slot_if.address}, 64'h0);
            chk("rst_data", {32'h0, slot_if.data}, 64'h0);
            chk("rst_byte_en", {60'h0, slot_if.byte_en}, 64'h0);
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: word %0d not written, expected at cycle %0d", wq[0].addr, wq[0].cyc);
            void'(wq.pop_front());
        end
        if (slot_if.wr_en === 1'b1) begin
            n_wr++;
            if (slot_if.address == ADDR_LEN) hdr_len_seen = slot_if.data;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("wr_address", {53'h0, slot_if.address}, {53'h0, wq[0].addr});
                chk("wr_byte_en", {60'h0, slot_if.byte_en}, {60'h0, wq[0].be});
                chk("wr_data", {32'h0, slot_if.data}, {32'h0, wq[0].data});
                void'(wq.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: word %0d data %0h, expected none (cycle %0d)",
                         slot_if.address, slot_if.data, cyc);
            end
        end
        while (cq.size() > 0 && cq[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_rx_complete: got none, expected at cycle %0d", cq[0]);
            void'(cq.pop_front());
        end
        if (rx_complete === 1'b1) begin
            n_cmp++;
            checks++;
            if (cq.size() > 0 && cq[0] == cyc) begin
                void'(cq.pop_front());
            end else begin
                errors++;
                $display("FAIL unexpected_rx_complete: got 1, expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        @(posedge pci_clk);
        #1;
    endtask

    task automatic purge(input int from);
        while (wq.size() > 0 && wq[$].cyc >= from) void'(wq.pop_back());
        while (cq.size() > 0 && cq[$] >= from) void'(cq.pop_back());
    endtask

    // A frame is stored only if it starts with preamble, carries SFD, finds the
    // slot free at SFD and begins once the receiver has finished the last header.
    task automatic send_frame(input int npre, input bit bad, input int nbytes, input bit empty,
                              input bit ramp, input int gap, input int rst_at, input bit flip_empty);
        int          start;
        int          cnt;
        int          last;
        bit          ok;
        logic [63:0] ts;
        logic [7:0]  b;
        start = cyc;
        cnt   = 0;
        ts    = 64'd0;
        ok    = (npre >= 1) && !bad && empty && (start >= rx_free);
        rx_empty = empty;
        for (int i = 0; i < npre; i++) drive(1'b1, PREAMBLE);
        if (bad) begin
            drive(1'b1, 8'h12);
        end else begin
            ts = exp_cnt + 64'd1;
            drive(1'b1, SFD);
        end
        for (int i = 0; i < nbytes; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            if (i == rst_at) begin
                sys_rst = 1'b1;
                purge(cyc + 1);
                ok = 1'b0;
            end
            if (i == rst_at + 2) sys_rst = 1'b0;
            if (flip_empty && i == 2) rx_empty = 1'($urandom_range(0, 1));
            if (ok && cnt < MAX_DATA_BYTES) begin
                wq.push_back('{cyc + 2, 11'(4 + cnt / 4), 4'(1 << (cnt % 4)), {4{b}}});
                cnt++;
            end
            drive(1'b1, b);
        end
        sys_rst = 1'b0;
        last = cyc;
        drive(1'b0, 8'h00);
        if (ok && cnt > 0) begin
            wq.push_back('{last + 3, ADDR_LEN, 4'hF, {16'h0, 16'(cnt)}});
            wq.push_back('{last + 4, ADDR_TSL, 4'hF, ts[31:0]});
            wq.push_back('{last + 5, ADDR_TSH, 4'hF, ts[63:32]});
            cq.push_back(last + 6);
            rx_free = last + 5;
        end else begin
            rx_free = (rx_free > last + 1) ? rx_free : last + 1;
        end
        for (int i = 1; i < gap; i++) drive(1'b0, 8'h00);
    endtask

    int w0, c0;

    initial begin
        repeat (3) drive(1'b0, 8'h00);
        sys_rst = 1'b0;
        repeat (3) drive(1'b0, 8'h00);

        // 64-byte ramp frame into a free slot
        w0 = n_wr; c0 = n_cmp;
        send_frame(7, 1'b0, 64, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("frame64_writes", 64'(n_wr - w0), 64'd67);
        chk("frame64_complete", 64'(n_cmp - c0), 64'd1);
        chk("frame64_len", {32'h0, hdr_len_seen}, 64'h40);

        // same frame with the slot busy
        w0 = n_wr; c0 = n_cmp;
        send_frame(7, 1'b0, 64, 1'b0, 1'b1, 10, -1, 1'b0);
        chk("busy_writes", 64'(n_wr - w0), 64'd0);
        chk("busy_complete", 64'(n_cmp - c0), 64'd0);

        // broken preamble, then a good frame
        w0 = n_wr;
        send_frame(2, 1'b1, 10, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("badpre_writes", 64'(n_wr - w0), 64'd0);
        w0 = n_wr;
        send_frame(7, 1'b0, 16, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("after_bad_writes", 64'(n_wr - w0), 64'd19);

        // counter clear
        global_counter_rst = 1'b1;
        drive(1'b0, 8'h00);
        global_counter_rst = 1'b0;
        @(negedge pci_clk); chk("gcr_0", global_counter, 64'd0);
        @(posedge pci_clk); #1;
        @(negedge pci_clk); chk("gcr_1", global_counter, 64'd1);
        @(posedge pci_clk); #1;
        @(negedge pci_clk); chk("gcr_2", global_counter, 64'd2);
        @(posedge pci_clk); #1;

        // 5-byte frame
        w0 = n_wr;
        send_frame(7, 1'b0, 5, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("frame5_writes", 64'(n_wr - w0), 64'd8);
        chk("frame5_len", {32'h0, hdr_len_seen}, 64'd5);

        // reset during data, then a normal frame
        w0 = n_wr; c0 = n_cmp;
        send_frame(7, 1'b0, 64, 1'b1, 1'b1, 10, 20, 1'b0);
        chk("rstmid_writes", 64'(n_wr - w0), 64'd19);
        chk("rstmid_complete", 64'(n_cmp - c0), 64'd0);
        w0 = n_wr; c0 = n_cmp;
        send_frame(7, 1'b0, 12, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("after_rst_writes", 64'(n_wr - w0), 64'd15);
        chk("after_rst_complete", 64'(n_cmp - c0), 64'd1);

        // frame starting while the previous header is still going out
        w0 = n_wr; c0 = n_cmp;
        send_frame(7, 1'b0, 8, 1'b1, 1'b0, 2, -1, 1'b0);
        send_frame(7, 1'b0, 8, 1'b1, 1'b0, 10, -1, 1'b0);
        chk("overlap_writes", 64'(n_wr - w0), 64'd11);
        chk("overlap_complete", 64'(n_cmp - c0), 64'd1);

        // slot capacity limit
        w0 = n_wr;
        send_frame(1, 1'b0, 8180, 1'b1, 1'b1, 10, -1, 1'b0);
        chk("cap_writes", 64'(n_wr - w0), 64'd8179);
        chk("cap_len", {32'h0, hdr_len_seen}, 64'h1FF0);

        for (int f = 0; f < 40; f++) begin
            send_frame(int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                       int'($urandom_range(0, 40)), $urandom_range(0, 3) != 0,
                       1'b0, int'($urandom_range(1, 8)), -1, 1'b1);
        end

        repeat (12) drive(1'b0, 8'h00);
        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_complete", 64'(cq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not end, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
